// File: rtl/say_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : say_arbiter
// Description : Four-way round-robin arbiter that feeds a one-entry output
//               buffer toward a shared say channel. A requester can be
//               granted in the same cycle that the buffered transaction
//               drains, so the channel sustains one transaction per cycle.
//               Optional per-requester grant counters and a transfer
//               counter are built only when SAY_ARBITER_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module say_arbiter #(
  parameter int V_WIDTH   = 32,
  parameter int SEQ_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 nRST,

  input  logic                 say0__ENA,
  input  logic [V_WIDTH-1:0]   say0_v,
  input  logic [SEQ_WIDTH-1:0] say0_seqno,
  output logic                 say0__RDY,

  input  logic                 say1__ENA,
  input  logic [V_WIDTH-1:0]   say1_v,
  input  logic [SEQ_WIDTH-1:0] say1_seqno,
  output logic                 say1__RDY,

  input  logic                 say2__ENA,
  input  logic [V_WIDTH-1:0]   say2_v,
  input  logic [SEQ_WIDTH-1:0] say2_seqno,
  output logic                 say2__RDY,

  input  logic                 say3__ENA,
  input  logic [V_WIDTH-1:0]   say3_v,
  input  logic [SEQ_WIDTH-1:0] say3_seqno,
  output logic                 say3__RDY,

  output logic                 out_say__ENA,
  output logic [V_WIDTH-1:0]   out_say_v,
  output logic [SEQ_WIDTH-1:0] out_say_seqno,
  output logic [1:0]           out_say_src,
  input  logic                 out_say__RDY,

  output logic [7:0]           stat0,
  output logic [7:0]           stat1,
  output logic [7:0]           stat2,
  output logic [7:0]           stat3,
  output logic [31:0]          statTotal
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]           r_state;
  logic [1:0]           r_ptr;
  logic [V_WIDTH-1:0]   r_v;
  logic [SEQ_WIDTH-1:0] r_seqno;
  logic [1:0]           r_src;

  logic [3:0]           w_req;
  logic [V_WIDTH-1:0]   w_v_in   [4];
  logic [SEQ_WIDTH-1:0] w_seq_in [4];
  logic                 w_drain;
  logic                 w_open;
  logic                 w_any_grant;
  logic [1:0]           w_gidx;
  logic [3:0]           w_grant;

  assign w_req       = {say3__ENA, say2__ENA, say1__ENA, say0__ENA};
  assign w_v_in[0]   = say0_v;
  assign w_v_in[1]   = say1_v;
  assign w_v_in[2]   = say2_v;
  assign w_v_in[3]   = say3_v;
  assign w_seq_in[0] = say0_seqno;
  assign w_seq_in[1] = say1_seqno;
  assign w_seq_in[2] = say2_seqno;
  assign w_seq_in[3] = say3_seqno;

  // A drain frees the buffer in the same cycle, so a new grant can refill it.
  assign w_drain = (r_state == ST_FULL) && out_say__RDY;
  assign w_open  = (r_state == ST_EMPTY) || w_drain;

  // Round-robin search from r_ptr; the loop runs high-to-low so the nearest
  // requester after the pointer is the last (winning) assignment. Reset gates
  // grants so no requester sees RDY while nRST is low.
  always_comb begin
    w_gidx      = 2'd0;
    w_any_grant = 1'b0;
    w_grant     = 4'b0000;
    if (nRST && w_open && (|w_req)) begin
      w_any_grant = 1'b1;
      for (int k = 3; k >= 0; k--) begin
        if (w_req[r_ptr + 2'(k)]) begin
          w_gidx = r_ptr + 2'(k);
        end
      end
      w_grant = 4'b0001 << w_gidx;
    end
  end

  assign say0__RDY = w_grant[0];
  assign say1__RDY = w_grant[1];
  assign say2__RDY = w_grant[2];
  assign say3__RDY = w_grant[3];

  // Buffer state, round-robin pointer and payload capture.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= ST_EMPTY;
      r_ptr   <= 2'd0;
      r_v     <= '0;
      r_seqno <= '0;
      r_src   <= 2'd0;
    end else begin
      if (w_any_grant) begin
        r_state <= ST_FULL;
        r_v     <= w_v_in[w_gidx];
        r_seqno <= w_seq_in[w_gidx];
        r_src   <= w_gidx;
        r_ptr   <= w_gidx + 2'd1;
      end else if (w_drain) begin
        // Payload is intentionally left as-is; only validity drops.
        r_state <= ST_EMPTY;
      end
    end
  end

  assign out_say__ENA  = (r_state == ST_FULL);
  assign out_say_v     = r_v;
  assign out_say_seqno = r_seqno;
  assign out_say_src   = r_src;

`ifdef SAY_ARBITER_STATS_EN
  logic [7:0]  r_stat [4];
  logic [31:0] r_total;

  // Grant counters per requester and a completed-transfer counter; both wrap.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < 4; i++) begin
        r_stat[i] <= 8'd0;
      end
      r_total <= 32'd0;
    end else begin
      if (w_any_grant) begin
        r_stat[w_gidx] <= r_stat[w_gidx] + 8'd1;
      end
      if (w_drain) begin
        r_total <= r_total + 32'd1;
      end
    end
  end

  assign stat0     = r_stat[0];
  assign stat1     = r_stat[1];
  assign stat2     = r_stat[2];
  assign stat3     = r_stat[3];
  assign statTotal = r_total;
`else
  assign stat0     = 8'd0;
  assign stat1     = 8'd0;
  assign stat2     = 8'd0;
  assign stat3     = 8'd0;
  assign statTotal = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_say_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_say_arbiter
// Description : Scoreboard bench for say_arbiter. Grants are predicted by a
//               round-robin model, pushed to a queue, and compared against
//               the buffered output until it drains.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_say_arbiter;

  localparam int VW = 32;
  localparam int SW = 8;

  typedef struct packed {
    logic [VW-1:0] v;
    logic [SW-1:0] s;
    logic [1:0]    src;
  } ent_t;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic [3:0]    ena;
  logic [VW-1:0] v  [4];
  logic [SW-1:0] sq [4];
  logic          o_rdy;
  wire  [3:0]    rdy;
  wire           o_ena;
  wire  [VW-1:0] o_v;
  wire  [SW-1:0] o_sq;
  wire  [1:0]    o_src;
  wire  [7:0]    st0, st1, st2, st3;
  wire  [31:0]   stt;

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          mon_en  = 1'b0;
  ent_t        q[$];
  logic [1:0]  glog[$];
  int          m_ptr = 0;
  int          m_stat[4];
  int          m_total = 0;

  logic        m_full, m_drain, m_open, m_found;
  logic [1:0]  m_gi;
  ent_t        m_e;
  int          cnt[4];

  always #5 CLK = ~CLK;

  say_arbiter #(.V_WIDTH(VW), .SEQ_WIDTH(SW)) dut (
    .CLK(CLK), .nRST(nRST),
    .say0__ENA(ena[0]), .say0_v(v[0]), .say0_seqno(sq[0]), .say0__RDY(rdy[0]),
    .say1__ENA(ena[1]), .say1_v(v[1]), .say1_seqno(sq[1]), .say1__RDY(rdy[1]),
    .say2__ENA(ena[2]), .say2_v(v[2]), .say2_seqno(sq[2]), .say2__RDY(rdy[2]),
    .say3__ENA(ena[3]), .say3_v(v[3]), .say3_seqno(sq[3]), .say3__RDY(rdy[3]),
    .out_say__ENA(o_ena), .out_say_v(o_v), .out_say_seqno(o_sq),
    .out_say_src(o_src), .out_say__RDY(o_rdy),
    .stat0(st0), .stat1(st1), .stat2(st2), .stat3(st3), .statTotal(stt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    m_ptr   = 0;
    m_total = 0;
    for (int i = 0; i < 4; i++) m_stat[i] = 0;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < 4; i++) begin
      v[i]  = $urandom;
      sq[i] = 8'($urandom);
    end
  endtask

  function automatic logic [7:0] exp_stat(input int n);
`ifdef SAY_ARBITER_STATS_EN
    return 8'(n);
`else
    return 8'd0 + 8'(n & 0) ;
`endif
  endfunction

  function automatic logic [31:0] exp_total(input int n);
`ifdef SAY_ARBITER_STATS_EN
    return 32'(n);
`else
    return 32'd0 + 32'(n & 0);
`endif
  endfunction

  // Monitor: predict grants, check the buffer against the scoreboard front.
  always @(negedge CLK) begin
    if (mon_en && nRST) begin
      m_full = (q.size() != 0);
      chk("out_ena", o_ena, m_full);
      if (m_full && q.size() != 0) begin
        chk("out_v", o_v, q[0].v);
        chk("out_seqno", o_sq, q[0].s);
        chk("out_src", o_src, q[0].src);
      end
      m_drain = m_full && o_rdy;
      m_open  = !m_full || m_drain;
      m_found = 1'b0;
      m_gi    = 2'd0;
      if (m_open) begin
        for (int k = 0; k < 4; k++) begin
          if (!m_found && ena[(m_ptr + k) % 4]) begin
            m_found = 1'b1;
            m_gi    = 2'((m_ptr + k) % 4);
          end
        end
      end
      chk("rdy", rdy, m_found ? (4'b0001 << m_gi) : 4'b0000);
      if (m_drain && q.size() != 0) begin
        void'(q.pop_front());
        m_total++;
      end
      if (m_found) begin
        m_e.v   = v[m_gi];
        m_e.s   = sq[m_gi];
        m_e.src = m_gi;
        q.push_back(m_e);
        m_ptr = (int'(m_gi) + 1) % 4;
        m_stat[m_gi]++;
        glog.push_back(m_gi);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ena   = 4'hF;
    o_rdy = 1'b1;
    rand_payload();
    model_reset();
    #12;
    // Reset state, with every requester asking and the channel ready.
    chk("rst_rdy", rdy, 4'b0000);
    chk("rst_ena", o_ena, 1'b0);
    chk("rst_v", o_v, 32'd0);
    chk("rst_src", o_src, 2'd0);
    chk("rst_stat0", st0, 8'd0);
    chk("rst_total", stt, 32'd0);

    // Alternating pair with channel always ready; first grant right after reset.
    ena = 4'b0101;
    @(posedge CLK);
    #1;
    nRST   = 1'b1;
    mon_en = 1'b1;
    glog.delete();
    repeat (4) begin
      step();
      rand_payload();
    end
    chk("pair_cnt", glog.size(), 4);
    chk("pair_g0", glog[0], 2'd0);
    chk("pair_g1", glog[1], 2'd2);
    chk("pair_g2", glog[2], 2'd0);
    chk("pair_g3", glog[3], 2'd2);
    ena = 4'b0000;
    step();
    step();

    // Hold a transaction while the channel stalls.
    ena   = 4'b0010;
    v[1]  = 32'h1234;
    sq[1] = 8'h05;
    o_rdy = 1'b0;
    step();
    ena = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_ena", o_ena, 1'b1);
      chk("hold_v", o_v, 32'h1234);
      chk("hold_seq", o_sq, 8'h05);
      chk("hold_src", o_src, 2'd1);
      chk("hold_rdy", rdy, 4'b0000);
    end
    ena   = 4'b0000;
    o_rdy = 1'b1;
    step();
    step();

    // Drain and grant in the same cycle, no bubble.
    ena  = 4'b0001;
    v[0] = 32'hAAAA_0001;
    step();
    ena  = 4'b0010;
    v[1] = 32'hBBBB_0002;
    step();
    ena = 4'b0000;
    chk("b2b_ena", o_ena, 1'b1);
    chk("b2b_v", o_v, 32'hBBBB_0002);
    chk("b2b_src", o_src, 2'd1);
    step();
    step();

    // All four requesting, channel ready toggling.
    glog.delete();
    ena = 4'hF;
    for (int i = 0; i < 20; i++) begin
      o_rdy = i[0] ? 1'b0 : 1'b1;
      rand_payload();
      step();
    end
    ena   = 4'b0000;
    o_rdy = 1'b1;
    step();
    step();
    chk("fair_cnt", (glog.size() >= 8) ? 1 : 0, 1);
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int i = 0; i < 8 && i < glog.size(); i++) cnt[glog[i]]++;
    for (int i = 0; i < 4; i++) chk($sformatf("fair_req%0d", i), cnt[i], 2);
    chk("sb_empty", q.size(), 0);

    // Asynchronous reset while full; pointer restarts at requester 0.
    o_rdy = 1'b0;
    ena   = 4'b0100;
    step();
    ena = 4'b0000;
    chk("prerst_ena", o_ena, 1'b1);
    #1;
    nRST = 1'b0;
    model_reset();
    #1;
    chk("arst_ena", o_ena, 1'b0);
    chk("arst_v", o_v, 32'd0);
    chk("arst_src", o_src, 2'd0);
    ena = 4'hF;
    #1;
    chk("arst_rdy", rdy, 4'b0000);
    step();
    nRST = 1'b1;
    glog.delete();
    step();
    chk("arst_first", glog[0], 2'd0);
    ena   = 4'b0000;
    o_rdy = 1'b1;
    step();
    step();

    // Long run on requester 3 to exercise counter wrap.
    ena = 4'b1000;
    for (int i = 0; i < 300; i++) begin
      rand_payload();
      step();
    end
    ena = 4'b0000;
    step();
    step();
    chk("stat3", st3, exp_stat(m_stat[3]));
    chk("stat0", st0, exp_stat(m_stat[0]));
    chk("stat_total", stt, exp_total(m_total));
    chk("sb_final", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/say_arbiter.md
SAY_ARBITER -- requirements
Module: say_arbiter

Interface
REQ-001 SHALL have parameter V_WIDTH, default 32, which sets the say$v payload width.
REQ-002 SHALL have parameter SEQ_WIDTH, default 8, which sets the say$seqno payload width.
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 nRST  input  1  reset, asynchronous, active-low.
REQ-005 sayN__ENA  input  1  requester N (N=0..3) offers a say transaction.
REQ-006 sayN$v  input  V_WIDTH  requester N payload.
REQ-007 sayN$seqno  input  SEQ_WIDTH  requester N sequence number.
REQ-008 sayN__RDY  output  1  requester N is granted this cycle.
REQ-009 out$say__ENA  output  1  buffered transaction valid toward the shared say channel.
REQ-010 out$say$v  output  V_WIDTH  buffered payload.
REQ-011 out$say$seqno  output  SEQ_WIDTH  buffered sequence number.
REQ-012 out$say$src  output  2  index of the requester that owns the buffered transaction.
REQ-013 out$say__RDY  input  1  shared channel accepts this cycle.
REQ-014 statN  output  8  grant count for requester N (N=0..3).
REQ-015 statTotal  output  32  count of completed output transfers.

Function
REQ-016 SHALL hold a one-entry output buffer with states EMPTY (out$say__ENA=0) and FULL (out$say__ENA=1).
REQ-017 Drain: a transfer SHALL occur in any cycle with out$say__ENA and out$say__RDY both high.
REQ-018 Accept window: open SHALL be 1 when the state is EMPTY or a drain occurs in the same cycle; otherwise 0.
REQ-019 sayN__RDY SHALL be 1 for at most one N per cycle, the first N with sayN__ENA=1 searching round-robin from pointer ptr, and only while open is 1.
REQ-020 sayN__RDY SHALL be combinational from sayN__ENA, ptr, state and out$say__RDY, with no dependency on payload.
REQ-021 On grant of N, the buffer SHALL load sayN$v, sayN$seqno and src=N at the next edge, and the state SHALL become or remain FULL.
REQ-022 On grant of N, ptr SHALL become (N+1) mod 4; with no grant, ptr SHALL be unchanged.
REQ-023 On a drain with no grant, the state SHALL become EMPTY; the payload registers SHALL keep their values.
REQ-024 Simultaneous drain and grant SHALL keep the state FULL with the new payload, giving one transaction per cycle of throughput.
REQ-025 Latency from grant to out$say__ENA SHALL be exactly 1 cycle.
REQ-026 While FULL and out$say__RDY=0, all out$say* outputs SHALL be stable and every sayN__RDY SHALL be 0.
REQ-027 A requester that holds ENA SHALL be granted within 4 accept windows.
REQ-028 A transaction SHALL never be dropped or duplicated; each grant SHALL produce exactly one drain.

Reset
REQ-029 nRST low SHALL immediately force state EMPTY, ptr=0, payload=0, src=0, statN=0 and statTotal=0, even with a transaction in the buffer.
REQ-030 While nRST is low, every sayN__RDY SHALL be 0.
REQ-031 The first grant SHALL be possible on the first rising edge after nRST deasserts.

Configuration
REQ-032 With SAY_ARBITER_STATS_EN defined, statN SHALL increment by 1 per grant to N, wrapping 255->0, and statTotal SHALL increment by 1 per drain, wrapping.
REQ-033 Without SAY_ARBITER_STATS_EN, no counter registers SHALL exist and statN and statTotal SHALL be constant 0; all other behaviour SHALL be identical.

Verification
REQ-034 say0 and say2 both ENA with out$say__RDY=1 held high, after reset -> grants in order 0,2,0,2; out$say$src follows 1 cycle later; one drain per cycle.
REQ-035 say1 ENA with v=0x1234, seqno=0x05, and out$say__RDY=0 for 3 cycles -> FULL holds v=0x1234, src=1 stable; all sayN__RDY=0 until out$say__RDY rises.
REQ-036 All four requesters ENA continuously with out$say__RDY toggling 1,0 -> each requester granted exactly once per 4 grants; no transaction lost (scoreboard).
REQ-037 nRST pulsed low mid-cycle while FULL -> out$say__ENA drops before the next edge; ptr restarts so say0 wins the next contention.
REQ-038 With STATS_EN, 300 grants to say3 -> stat3 = 300 mod 256 = 44 and statTotal = 300; without STATS_EN, both read 0.
REQ-039 Drain and new grant in the same cycle -> out$say__ENA stays 1 with the new payload; no bubble.
